// File: rtl/nas_vram_pkg.sv
// nas_vram_pkg: shared types and constants for the Nascom 2 VDU RAM arbiter.
// Optional feature macro (used by nas_vram_arb): NAS_VRAM_SNOW_EN.
package nas_vram_pkg;

  localparam int AW_DEF = 10;
  localparam int DW_DEF = 8;

  // Slot phases owned by the character scan-out.
  localparam logic [2:0] VID_ADDR_PH = 3'd0;
  localparam logic [2:0] VID_DATA_PH = 3'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/nas_vram_arb_if.sv
// nas_vram_arb_if: CPU-side request/ack bus into the VDU RAM arbiter.
// master = CPU bus decode, slave = arbiter.
interface nas_vram_arb_if #(
  parameter int AW = 10,
  parameter int DW = 8
) ();

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          cpu_wait;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_wait
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_wait
  );

endinterface

// File: rtl/nas_vram_phase.sv
// nas_vram_phase: free-running 3-bit character-slot phase counter with
// decodes for the video address and video data-return phases.
module nas_vram_phase
  import nas_vram_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] ph,
  output logic       addr_slot,
  output logic       data_slot
);

  // Advance the phase every pixel clock, wrapping 7 -> 0.
  always_ff @(posedge clk) begin
    if (reset) ph <= 3'd0;
    else       ph <= ph + 3'd1;
  end

  assign addr_slot = (ph == VID_ADDR_PH);
  assign data_slot = (ph == VID_DATA_PH);

endmodule

// File: rtl/nas_vram_arb.sv
// nas_vram_arb: shares the 1Kx8 VDU RAM between the Z80 and character scan-out.
// Phase 0 of every 8-cycle slot is reserved for the video fetch while vid_en is
// high; CPU accesses land in any other phase and are stretched with WAIT.
// Optional feature macro: NAS_VRAM_SNOW_EN -- CPU always wins the RAM and a
// collision with the video slot shows up on screen as "snow".
module nas_vram_arb
  import nas_vram_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  nas_vram_arb_if.slave cpu,
  input  logic          vid_en,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_data,
  output logic [2:0]    ph,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  arb_state_t    state;
  logic          ack_q;
  logic [DW-1:0] rdata_q;
  logic          addr_slot;
  logic          data_slot;
  logic          grant;
  logic          cpu_sel;
  logic          vid_fetch;

  nas_vram_phase u_phase (
    .clk       (clk),
    .reset     (reset),
    .ph        (ph),
    .addr_slot (addr_slot),
    .data_slot (data_slot)
  );

`ifdef NAS_VRAM_SNOW_EN
  assign grant = 1'b1;
`else
  assign grant = ~(vid_en & addr_slot);
`endif

  assign cpu_sel = (state == ACC) & grant;

  // RAM port mux; the write strobe is masked during reset so an access caught
  // mid-flight never reaches the RAM.
  always_comb begin
    ram_addr  = cpu_sel ? cpu.cpu_addr : vid_addr;
    ram_we    = cpu_sel & cpu.cpu_we & ~reset;
    ram_wdata = cpu.cpu_wdata;
  end

  assign cpu.cpu_ack   = ack_q;
  assign cpu.cpu_rdata = rdata_q;
  assign cpu.cpu_wait  = cpu.cpu_req & (state != DONE);

  // CPU access FSM; ack is a single pulse on entry to DONE, and DONE is only
  // left once the request drops so a held request is served once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        IDLE: if (cpu.cpu_req) state <= ACC;
        ACC: begin
          if (grant) begin
            if (cpu.cpu_we) begin
              state <= DONE;
              ack_q <= 1'b1;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          rdata_q <= ram_rdata;
          state   <= DONE;
          ack_q   <= 1'b1;
        end
        DONE: if (!cpu.cpu_req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NAS_VRAM_SNOW_EN
  logic          snow_wr;
  logic [DW-1:0] snow_wdata;

  // Remember a CPU write that stole the video address slot; its data is what
  // the shifter sees instead of the RAM contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      snow_wr    <= 1'b0;
      snow_wdata <= '0;
    end else begin
      snow_wr    <= addr_slot & vid_en & (state == ACC) & cpu.cpu_we;
      snow_wdata <= cpu.cpu_wdata;
    end
  end
`endif

  // Video fetch: address at phase 0, capture the returned code at end of phase 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      vid_fetch <= 1'b0;
      vid_data  <= '0;
    end else begin
      vid_fetch <= vid_en & addr_slot;
      if (data_slot && vid_fetch) begin
`ifdef NAS_VRAM_SNOW_EN
        vid_data <= snow_wr ? snow_wdata : ram_rdata;
`else
        vid_data <= ram_rdata;
`endif
      end
    end
  end

endmodule
